// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational MIPS ALU: issue, capture, respond.
// Optional saturating statistics counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [31:0]       req0_instr,
  input  logic [31:0]       req0_a,
  input  logic [31:0]       req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [31:0]       req1_instr,
  input  logic [31:0]       req1_a,
  input  logic [31:0]       req1_b,
  output logic [31:0]       alu_instruction,
  output logic [31:0]       alu_regA,
  output logic [31:0]       alu_regB,
  input  logic [31:0]       alu_result,
  input  logic [2:0]        alu_flags,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [31:0]       resp_result,
  output logic [2:0]        resp_flags
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_ops0,
  output logic [STAT_W-1:0] stat_ops1,
  output logic [STAT_W-1:0] stat_ovf
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   last_grant;
  logic   gnt;
  logic   any_vld;
  logic   take;
  logic   resp_done;

  // gnt selects requester 1 when high; only meaningful while any_vld is set.
  always_comb begin
    any_vld = req0_valid | req1_valid;
    if (PRIO_MODE == 1)
      gnt = ~req0_valid;
    else if (req0_valid && req1_valid)
      gnt = ~last_grant;
    else
      gnt = ~req0_valid;
  end

  assign take       = rst_n && (state == IDLE) && any_vld;
  assign req0_ready = take && !gnt;
  assign req1_ready = take && gnt;
  assign resp_done  = (state == RESP) && resp_valid && resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      alu_instruction <= '0;
      alu_regA        <= '0;
      alu_regB        <= '0;
      resp_valid      <= 1'b0;
      resp_id         <= 1'b0;
      resp_result     <= '0;
      resp_flags      <= '0;
    end else begin
      case (state)
        // Issue stage: register the granted operation onto the ALU inputs.
        IDLE: begin
          if (any_vld) begin
            alu_instruction <= gnt ? req1_instr : req0_instr;
            alu_regA        <= gnt ? req1_a     : req0_a;
            alu_regB        <= gnt ? req1_b     : req0_b;
            resp_id         <= gnt;
            last_grant      <= gnt;
            state           <= EXEC;
          end
        end
        // Capture stage: the ALU has had a full cycle on the registered operands.
        EXEC: begin
          resp_result <= alu_result;
          resp_flags  <= alu_flags;
          resp_valid  <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    if (en && (v != {STAT_W{1'b1}}))
      return v + {{(STAT_W-1){1'b0}}, 1'b1};
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops0 <= '0;
      stat_ops1 <= '0;
      stat_ovf  <= '0;
    end else if (resp_done) begin
      stat_ops0 <= sat_inc(stat_ops0, !resp_id);
      stat_ops1 <= sat_inc(stat_ops1, resp_id);
      stat_ovf  <= sat_inc(stat_ovf, resp_flags[0]);
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin instance (dut) and fixed-priority instance (dut_p)
// share requester stimulus; each drives its own behavioural MIPS ALU model.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0v, r1v, resp_ready;
  logic [31:0] r0i, r0a, r0b, r1i, r1a, r1b;

  logic        a_rdy0, a_rdy1, a_rv, a_id;
  logic [31:0] a_ins, a_ra, a_rb, a_res, a_rr;
  logic [2:0]  a_flg, a_rf;
  logic        b_rdy0, b_rdy1, b_rv, b_id;
  logic [31:0] b_ins, b_ra, b_rb, b_res, b_rr;
  logic [2:0]  b_flg, b_rf;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] a_s0, a_s1, a_sv;
  logic [1:0]  b_s0, b_s1, b_sv;
`endif

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] ADD_I = 32'h0020_0020;
  localparam logic [31:0] SUB_I = 32'h0022_1822;
  localparam logic [31:0] AND_I = 32'h0022_1824;
  localparam logic [31:0] OR_I  = 32'h0022_1825;
  localparam logic [31:0] SLT_I = 32'h0022_182a;
  localparam logic [31:0] BEQ_I = 32'h1022_0004;

  always #5 clk = ~clk;

  // Returns {flags[2:0], result}: flags = {zero, negative, overflow}.
  function automatic logic [34:0] alu_model(input logic [31:0] ins, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic        ovf;
    ovf = 1'b0;
    if (ins[31:26] == 6'h04) begin
      r = a - b;
    end else begin
      case (ins[5:0])
        6'h20: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
        6'h22: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h2a: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: r = a + b;
      endcase
    end
    return {(r == 32'd0), r[31], ovf, r};
  endfunction

  function automatic logic [31:0] rnd_instr();
    case ($urandom_range(0, 5))
      0: return ADD_I;
      1: return SUB_I;
      2: return AND_I;
      3: return OR_I;
      4: return SLT_I;
      default: return BEQ_I;
    endcase
  endfunction

  function automatic logic [31:0] rnd_opd();
    case ($urandom_range(0, 3))
      0: return 32'h4000_0000 | 32'($urandom_range(0, 15));
      1: return 32'h7fff_ffff;
      2: return 32'($urandom_range(0, 7));
      default: return $urandom;
    endcase
  endfunction

  assign {a_flg, a_res} = alu_model(a_ins, a_ra, a_rb);
  assign {b_flg, b_res} = alu_model(b_ins, b_ra, b_rb);

  alu_arbiter #(.PRIO_MODE(0), .STAT_W(16)) dut (
`ifdef ALU_ARB_STATS_EN
    .stat_ops0(a_s0), .stat_ops1(a_s1), .stat_ovf(a_sv),
`endif
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(a_rdy0), .req0_instr(r0i), .req0_a(r0a), .req0_b(r0b),
    .req1_valid(r1v), .req1_ready(a_rdy1), .req1_instr(r1i), .req1_a(r1a), .req1_b(r1b),
    .alu_instruction(a_ins), .alu_regA(a_ra), .alu_regB(a_rb),
    .alu_result(a_res), .alu_flags(a_flg),
    .resp_valid(a_rv), .resp_ready(resp_ready), .resp_id(a_id),
    .resp_result(a_rr), .resp_flags(a_rf)
  );

  alu_arbiter #(.PRIO_MODE(1), .STAT_W(2)) dut_p (
`ifdef ALU_ARB_STATS_EN
    .stat_ops0(b_s0), .stat_ops1(b_s1), .stat_ovf(b_sv),
`endif
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(b_rdy0), .req0_instr(r0i), .req0_a(r0a), .req0_b(r0b),
    .req1_valid(r1v), .req1_ready(b_rdy1), .req1_instr(r1i), .req1_a(r1a), .req1_b(r1b),
    .alu_instruction(b_ins), .alu_regA(b_ra), .alu_regB(b_rb),
    .alu_result(b_res), .alu_flags(b_flg),
    .resp_valid(b_rv), .resp_ready(resp_ready), .resp_id(b_id),
    .resp_result(b_rr), .resp_flags(b_rf)
  );

  task automatic do_reset;
    rst_n = 1'b0; r0v = 1'b0; r1v = 1'b0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; r0v = 1'b1; r1v = 1'b1; resp_ready = 1'b0;
    r0i = ADD_I; r0a = 32'd5; r0b = 32'd6; r1i = SUB_I; r1a = 32'd7; r1b = 32'd8;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({a_rdy0, a_rdy1, b_rdy0, b_rdy1} !== 4'b0) begin
      fails++; $display("FAIL reset_ready: got %b expected 0000", {a_rdy0, a_rdy1, b_rdy0, b_rdy1});
    end
    tests++;
    if ({a_ins, a_ra, a_rb} !== 96'h0) begin
      fails++; $display("FAIL reset_alu: got %h %h %h expected zeros", a_ins, a_ra, a_rb);
    end
    tests++;
    if ({a_rv, a_id, a_rr, a_rf} !== 37'h0 || {b_rv, b_id, b_rr, b_rf} !== 37'h0) begin
      fails++; $display("FAIL reset_resp: got %b %b %h %b expected zeros", a_rv, a_id, a_rr, a_rf);
    end
`ifdef ALU_ARB_STATS_EN
    tests++;
    if ({a_s0, a_s1, a_sv} !== 48'h0) begin
      fails++; $display("FAIL reset_stats: got %0d %0d %0d expected 0 0 0", a_s0, a_s1, a_sv);
    end
`endif
    @(negedge clk);
    r0v = 1'b0; r1v = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_add;
    @(posedge clk); #1;
    r0v = 1'b1; r0i = ADD_I; r0a = 32'd1; r0b = 32'd3; r1v = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({a_rdy0, a_rdy1} !== 2'b10) begin
      fails++; $display("FAIL add_ready: got %b expected 10", {a_rdy0, a_rdy1});
    end
    @(posedge clk); #1;
    r0v = 1'b0;
    @(negedge clk);
    tests++;
    if (a_rv !== 1'b0 || a_rdy0 !== 1'b0 || {a_ins, a_ra, a_rb} !== {ADD_I, 32'd1, 32'd3}) begin
      fails++; $display("FAIL add_exec: got vld=%b rdy=%b alu=%h/%h/%h expected 0 0 %h/1/3",
                        a_rv, a_rdy0, a_ins, a_ra, a_rb, ADD_I);
    end
    @(negedge clk);
    tests++;
    if (a_rv !== 1'b1 || a_id !== 1'b0 || a_rr !== 32'd4 || a_rf !== 3'b000) begin
      fails++; $display("FAIL add_resp: got vld=%b id=%b res=%h flg=%b expected 1 0 4 000",
                        a_rv, a_id, a_rr, a_rf);
    end
    tests++;
    if (b_rv !== 1'b1 || b_rr !== 32'd4) begin
      fails++; $display("FAIL add_resp_prio: got vld=%b res=%h expected 1 4", b_rv, b_rr);
    end
    @(negedge clk);
    tests++;
    if (a_rv !== 1'b0 || a_ra !== 32'd1 || a_rb !== 32'd3) begin
      fails++; $display("FAIL add_done_hold: got vld=%b a=%h b=%h expected 0 1 3", a_rv, a_ra, a_rb);
    end
  endtask

  task automatic test_tie_and_overflow;
    logic [34:0] exp0, exp1;
    logic        e;
    do_reset;
    exp0 = alu_model(ADD_I, 32'd1, 32'd3);
    exp1 = alu_model(ADD_I, 32'h4000_0000, 32'h4000_0000);
    @(posedge clk); #1;
    r0v = 1'b1; r0i = ADD_I; r0a = 32'd1; r0b = 32'd3;
    r1v = 1'b1; r1i = ADD_I; r1a = 32'h4000_0000; r1b = 32'h4000_0000;
    resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      e = (k % 2 == 1);
      @(negedge clk);
      tests++;
      if ({a_rdy0, a_rdy1} !== {~e, e}) begin
        fails++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, {a_rdy0, a_rdy1}, {~e, e});
      end
      tests++;
      if ({b_rdy0, b_rdy1} !== 2'b10) begin
        fails++; $display("FAIL prio_grant[%0d]: got %b expected 10", k, {b_rdy0, b_rdy1});
      end
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (a_rv !== 1'b1 || a_id !== e || {a_rf, a_rr} !== (e ? exp1 : exp0)) begin
        fails++; $display("FAIL rr_resp[%0d]: got vld=%b id=%b %h expected 1 %b %h",
                          k, a_rv, a_id, {a_rf, a_rr}, e, (e ? exp1 : exp0));
      end
      if (e) begin
        tests++;
        if (a_rr !== 32'h8000_0000 || a_rf[0] !== 1'b1) begin
          fails++; $display("FAIL overflow: got res=%h ovf=%b expected 80000000 1", a_rr, a_rf[0]);
        end
      end
      tests++;
      if (b_rv !== 1'b1 || b_id !== 1'b0 || {b_rf, b_rr} !== exp0) begin
        fails++; $display("FAIL prio_resp[%0d]: got vld=%b id=%b %h expected 1 0 %h",
                          k, b_rv, b_id, {b_rf, b_rr}, exp0);
      end
    end
    @(posedge clk); #1;
    r0v = 1'b0; r1v = 1'b0;
`ifdef ALU_ARB_STATS_EN
    @(negedge clk);
    tests++;
    if (a_s0 !== 16'd3 || a_s1 !== 16'd2 || a_sv !== 16'd2) begin
      fails++; $display("FAIL stats_rr: got %0d %0d %0d expected 3 2 2", a_s0, a_s1, a_sv);
    end
    tests++;
    if (b_s0 !== 2'd3 || b_s1 !== 2'd0 || b_sv !== 2'd0) begin
      fails++; $display("FAIL stats_sat: got %0d %0d %0d expected 3 0 0", b_s0, b_s1, b_sv);
    end
`endif
  endtask

  task automatic test_backpressure;
    logic [34:0] expb;
    expb = alu_model(BEQ_I, 32'h7f, 32'h7f);
    @(posedge clk); #1;
    r0v = 1'b1; r0i = BEQ_I; r0a = 32'h7f; r0b = 32'h7f; r1v = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (a_rdy0 !== 1'b1) begin
      fails++; $display("FAIL bp_ready0: got %b expected 1", a_rdy0);
    end
    @(posedge clk); #1;
    r0v = 1'b0; r1v = 1'b1; r1i = ADD_I; r1a = 32'd5; r1b = 32'd6;
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests++;
      if (a_rv !== 1'b1 || a_id !== 1'b0 || {a_rf, a_rr} !== expb || a_rf[2] !== 1'b1) begin
        fails++; $display("FAIL bp_hold[%0d]: got vld=%b id=%b %h expected 1 0 %h",
                          c, a_rv, a_id, {a_rf, a_rr}, expb);
      end
      tests++;
      if ({a_rdy0, a_rdy1, b_rdy0, b_rdy1} !== 4'b0) begin
        fails++; $display("FAIL bp_noready[%0d]: got %b expected 0000", c,
                          {a_rdy0, a_rdy1, b_rdy0, b_rdy1});
      end
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (a_rdy1 !== 1'b0) begin
      fails++; $display("FAIL bp_release_early: got %b expected 0", a_rdy1);
    end
    @(negedge clk);
    tests++;
    if ({a_rdy0, a_rdy1} !== 2'b01) begin
      fails++; $display("FAIL bp_ready_return: got %b expected 01", {a_rdy0, a_rdy1});
    end
    @(posedge clk); #1;
    r1v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (a_rv !== 1'b1 || a_id !== 1'b1 || a_rr !== 32'd11) begin
      fails++; $display("FAIL bp_next: got vld=%b id=%b res=%h expected 1 1 b", a_rv, a_id, a_rr);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_exec;
    @(posedge clk); #1;
    r0v = 1'b1; r0i = ADD_I; r0a = 32'd2; r0b = 32'd2; r1v = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    r1v = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({a_ins, a_ra, a_rb, a_rv, a_id, a_rr, a_rf} !== 133'h0) begin
      fails++; $display("FAIL rst_exec_zero: got alu=%h/%h/%h vld=%b res=%h expected zeros",
                        a_ins, a_ra, a_rb, a_rv, a_rr);
    end
    @(negedge clk);
    tests++;
    if ({a_rdy0, a_rdy1, b_rdy0, b_rdy1} !== 4'b0) begin
      fails++; $display("FAIL rst_exec_ready: got %b expected 0000", {a_rdy0, a_rdy1, b_rdy0, b_rdy1});
    end
    r0v = 1'b0; r1v = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (a_rv !== 1'b0 || b_rv !== 1'b0) begin
        fails++; $display("FAIL rst_no_resp[%0d]: got %b %b expected 0 0", c, a_rv, b_rv);
      end
    end
    @(posedge clk); #1;
    r0v = 1'b1; r0i = ADD_I; r0a = 32'd9; r0b = 32'd9;
    r1v = 1'b1; r1i = SUB_I; r1a = 32'd9; r1b = 32'd1;
    @(negedge clk);
    tests++;
    if ({a_rdy0, a_rdy1} !== 2'b10) begin
      fails++; $display("FAIL rst_tie: got %b expected 10", {a_rdy0, a_rdy1});
    end
    @(posedge clk); #1;
    r0v = 1'b0; r1v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (a_rv !== 1'b1 || a_id !== 1'b0 || a_rr !== 32'd18) begin
      fails++; $display("FAIL rst_after: got vld=%b id=%b res=%h expected 1 0 12", a_rv, a_id, a_rr);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic        p0, p1, busy, lg, eg0, eg1, exp_id;
    logic [31:0] i0, a0, b0, i1, a1, b1;
    logic [34:0] exp_rsp;
    int          age, n0, n1, nv;
    do_reset;
    p0 = 1'b0; p1 = 1'b0; busy = 1'b0; lg = 1'b1; exp_id = 1'b0; exp_rsp = '0;
    i0 = '0; a0 = '0; b0 = '0; i1 = '0; a1 = '0; b1 = '0;
    age = 0; n0 = 0; n1 = 0; nv = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      if (!p0) begin
        if ($urandom_range(0, 1) == 1) begin p0 = 1'b1; i0 = rnd_instr(); a0 = rnd_opd(); b0 = rnd_opd(); end
      end else if ($urandom_range(0, 7) == 0) p0 = 1'b0;
      if (!p1) begin
        if ($urandom_range(0, 1) == 1) begin p1 = 1'b1; i1 = rnd_instr(); a1 = rnd_opd(); b1 = rnd_opd(); end
      end else if ($urandom_range(0, 7) == 0) p1 = 1'b0;
      r0v = p0; r0i = i0; r0a = a0; r0b = b0;
      r1v = p1; r1i = i1; r1a = a1; r1b = b1;
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      eg0 = !busy && p0 && (!p1 || lg);
      eg1 = !busy && p1 && !eg0;
      tests++;
      if ({a_rdy0, a_rdy1} !== {eg0, eg1}) begin
        fails++; $display("FAIL rnd_grant[%0d]: got %b expected %b", cyc, {a_rdy0, a_rdy1}, {eg0, eg1});
      end
      if (busy) begin
        age++;
        tests++;
        if (a_rv !== (age >= 2)) begin
          fails++; $display("FAIL rnd_valid[%0d]: got %b expected %b", cyc, a_rv, (age >= 2));
        end
        if (age >= 2) begin
          tests++;
          if ({a_id, a_rf, a_rr} !== {exp_id, exp_rsp}) begin
            fails++; $display("FAIL rnd_resp[%0d]: got %b %h expected %b %h",
                              cyc, a_id, {a_rf, a_rr}, exp_id, exp_rsp);
          end
          if (resp_ready) begin
            busy = 1'b0;
            if (exp_id) n1++; else n0++;
            if (exp_rsp[32]) nv++;
          end
        end
      end else begin
        tests++;
        if (a_rv !== 1'b0) begin
          fails++; $display("FAIL rnd_idle_valid[%0d]: got %b expected 0", cyc, a_rv);
        end
      end
      if (eg0 || eg1) begin
        busy = 1'b1; age = 0; lg = eg1; exp_id = eg1;
        exp_rsp = eg1 ? alu_model(i1, a1, b1) : alu_model(i0, a0, b0);
        if (eg1) p1 = 1'b0; else p0 = 1'b0;
      end
    end
    @(posedge clk); #1;
    r0v = 1'b0; r1v = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
`ifdef ALU_ARB_STATS_EN
    tests++;
    if (a_s0 !== 16'(n0) || a_s1 !== 16'(n1) || a_sv !== 16'(nv)) begin
      fails++; $display("FAIL rnd_stats: got %0d %0d %0d expected %0d %0d %0d",
                        a_s0, a_s1, a_sv, n0, n1, nv);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_add();
    test_tie_and_overflow();
    test_backpressure();
    test_reset_mid_exec();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
